ex_mem_stage: RTL and testbench

- EX/MEM pipeline stage of the MIPS datapath. Sits directly downstream of Execute and consumes its Zero, ALUResult, PC_Plus_Branch, j_sll_two and RegDestSelected outputs.
- Registers Execute results and control bits for the Memory stage, with valid/stall/flush handling.
- Resolves branches and jumps to a single one-shot PC redirect, and exposes an EX/MEM forwarding source.

---
 rtl/ex_mem_stage_pkg.sv | 18 +
 rtl/ex_mem_redirect.sv | 38 +++
 rtl/ex_mem_stage.sv | 167 ++++++++++++++++
 tb/tb_ex_mem_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_stage_pkg.sv
// rtl/ex_mem_stage_pkg.sv - shared encodings for the EX/MEM pipeline stage
package ex_mem_stage_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_HELD  = 2'b10
  } state_e;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/ex_mem_redirect.sv
// rtl/ex_mem_redirect.sv - one-shot branch/jump redirect from registered EX/MEM contents
module ex_mem_redirect
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic              br,
  input  logic              zero,
  input  logic              jmp,
  input  logic [DATA_W-1:0] br_target,
  input  logic [DATA_W-1:0] pc4,
  input  logic [DATA_W-5:0] jq,
  input  logic              load,
  input  logic              flush,
  output logic              take,
  output logic [DATA_W-1:0] target
);

  logic redirect_done;

  assign take   = valid & ((br & zero) | jmp) & ~redirect_done;
  assign target = jmp ? {pc4[DATA_W-1 -: 4], jq} : br_target;

  // A held instruction keeps redirect_done set so its redirect fires only once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_done <= 1'b0;
    end else if (flush || load) begin
      redirect_done <= 1'b0;
    end else if (take) begin
      redirect_done <= 1'b1;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with stall/flush, redirect and forwarding
// Optional performance counters enabled by EX_MEM_PERF_CNT_EN.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              ex_valid,
  input  logic              Zero,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] PC_Plus_Branch,
  input  logic [DATA_W-5:0] j_sll_two,
  input  logic [DATA_W-1:0] PCPlusFour,
  input  logic [REG_AW-1:0] RegDestSelected,
  input  logic [DATA_W-1:0] Reg_Data2,
  input  logic              RegWrite,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemToReg,
  input  logic              Branch,
  input  logic              Jump,
  input  logic [1:0]        MemSize,
  input  logic              mem_stall,
  input  logic              flush,
  output logic              ex_stall,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_ALUResult,
  output logic [DATA_W-1:0] mem_StoreData,
  output logic [REG_AW-1:0] mem_RegDest,
  output logic              mem_RegWrite,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  output logic              mem_MemToReg,
  output logic [1:0]        mem_MemSize,
  output logic              PCSrc,
  output logic [DATA_W-1:0] PCTarget,
  output logic              squash_ex,
  output logic              fwd_en,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_bubble_cnt,
  output logic [31:0]       perf_redirect_cnt
);

  state_e            state_q, state_d;
  logic              load;
  logic              br_q, zero_q, jmp_q;
  logic [DATA_W-1:0] br_target_q, pc4_q;
  logic [DATA_W-5:0] jq_q;
  logic              take;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= ST_EMPTY;
    else      state_q <= state_d;
  end

  // An empty stage may be overwritten even while Memory is stalled.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (mem_stall && state_q != ST_EMPTY) begin
      state_d = ST_HELD;
    end else begin
      load    = 1'b1;
      state_d = ex_valid ? ST_FULL : ST_EMPTY;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      mem_ALUResult <= '0;
      mem_StoreData <= '0;
      mem_RegDest   <= '0;
      mem_MemSize   <= SZ_WORD;
      mem_RegWrite  <= 1'b0;
      mem_MemRead   <= 1'b0;
      mem_MemWrite  <= 1'b0;
      mem_MemToReg  <= 1'b0;
      br_q          <= 1'b0;
      zero_q        <= 1'b0;
      jmp_q         <= 1'b0;
      br_target_q   <= '0;
      pc4_q         <= '0;
      jq_q          <= '0;
    end else if (flush) begin
      mem_RegWrite <= 1'b0;
      mem_MemRead  <= 1'b0;
      mem_MemWrite <= 1'b0;
      mem_MemToReg <= 1'b0;
      br_q         <= 1'b0;
      jmp_q        <= 1'b0;
    end else if (load) begin
      mem_ALUResult <= ALUResult;
      mem_StoreData <= Reg_Data2;
      mem_RegDest   <= RegDestSelected;
      mem_MemSize   <= MemSize;
      mem_RegWrite  <= ex_valid & RegWrite & (RegDestSelected != REG_AW'(REG_ZERO));
      mem_MemRead   <= ex_valid & MemRead;
      mem_MemWrite  <= ex_valid & MemWrite;
      mem_MemToReg  <= ex_valid & MemToReg;
      br_q          <= ex_valid & Branch;
      zero_q        <= Zero;
      jmp_q         <= ex_valid & Jump;
      br_target_q   <= PC_Plus_Branch;
      pc4_q         <= PCPlusFour;
      jq_q          <= j_sll_two;
    end
  end

  assign mem_valid = (state_q != ST_EMPTY);
  assign ex_stall  = mem_stall & mem_valid;

  ex_mem_redirect #(.DATA_W(DATA_W)) u_redirect (
    .clk       (Clk),
    .rst_n     (Rst),
    .valid     (mem_valid),
    .br        (br_q),
    .zero      (zero_q),
    .jmp       (jmp_q),
    .br_target (br_target_q),
    .pc4       (pc4_q),
    .jq        (jq_q),
    .load      (load),
    .flush     (flush),
    .take      (take),
    .target    (PCTarget)
  );

  assign PCSrc     = take;
  assign squash_ex = take;

  // Loaded values are not ready until the Memory stage, so only ALU results forward.
  assign fwd_en   = mem_valid & mem_RegWrite & ~mem_MemRead;
  assign fwd_rd   = mem_RegDest;
  assign fwd_data = mem_ALUResult;

`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q, redirect_cnt_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      stall_cnt_q    <= '0;
      bubble_cnt_q   <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if (ex_stall)                      stall_cnt_q    <= stall_cnt_q + 32'd1;
      if (flush || (load && !ex_valid))  bubble_cnt_q   <= bubble_cnt_q + 32'd1;
      if (take)                          redirect_cnt_q <= redirect_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt    = stall_cnt_q;
  assign perf_bubble_cnt   = bubble_cnt_q;
  assign perf_redirect_cnt = redirect_cnt_q;
`else
  assign perf_stall_cnt    = 32'd0;
  assign perf_bubble_cnt   = 32'd0;
  assign perf_redirect_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - directed and randomized checks of ex_mem_stage against a slot model
module tb_ex_mem_stage;

  logic        Clk, Rst;
  logic        ex_valid, Zero;
  logic [31:0] ALUResult, PC_Plus_Branch, PCPlusFour, Reg_Data2;
  logic [27:0] j_sll_two;
  logic [4:0]  RegDestSelected;
  logic        RegWrite, MemRead, MemWrite, MemToReg, Branch, Jump;
  logic [1:0]  MemSize;
  logic        mem_stall, flush;
  logic        ex_stall, mem_valid;
  logic [31:0] mem_ALUResult, mem_StoreData;
  logic [4:0]  mem_RegDest;
  logic        mem_RegWrite, mem_MemRead, mem_MemWrite, mem_MemToReg;
  logic [1:0]  mem_MemSize;
  logic        PCSrc, squash_ex, fwd_en;
  logic [31:0] PCTarget, fwd_data;
  logic [4:0]  fwd_rd;
  logic [31:0] perf_stall_cnt, perf_bubble_cnt, perf_redirect_cnt;

  ex_mem_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .Clk(Clk), .Rst(Rst), .ex_valid(ex_valid), .Zero(Zero), .ALUResult(ALUResult),
    .PC_Plus_Branch(PC_Plus_Branch), .j_sll_two(j_sll_two), .PCPlusFour(PCPlusFour),
    .RegDestSelected(RegDestSelected), .Reg_Data2(Reg_Data2), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg), .Branch(Branch),
    .Jump(Jump), .MemSize(MemSize), .mem_stall(mem_stall), .flush(flush),
    .ex_stall(ex_stall), .mem_valid(mem_valid), .mem_ALUResult(mem_ALUResult),
    .mem_StoreData(mem_StoreData), .mem_RegDest(mem_RegDest), .mem_RegWrite(mem_RegWrite),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_MemToReg(mem_MemToReg),
    .mem_MemSize(mem_MemSize), .PCSrc(PCSrc), .PCTarget(PCTarget), .squash_ex(squash_ex),
    .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt),
    .perf_redirect_cnt(perf_redirect_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // The instruction occupying the Memory slot, plus whether it already redirected.
  typedef struct packed {
    logic        valid;
    logic [31:0] alu, sd, btgt, pc4;
    logic [27:0] jq;
    logic [4:0]  rd;
    logic        rw, mr, mw, mtr, br, zero, jmp;
    logic [1:0]  sz;
  } slot_t;

  slot_t       m;
  logic        m_redirected;
  int unsigned m_stalls, m_bubbles, m_redirects;
  int          n_cmp, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic m_take();
    return m.valid && ((m.br && m.zero) || m.jmp) && !m_redirected;
  endfunction

  task automatic model_reset();
    m = '0;
    m_redirected = 1'b0;
    m_stalls = 0; m_bubbles = 0; m_redirects = 0;
  endtask

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_edge();
    logic held;
    logic t;
    t    = m_take();
    held = mem_stall && m.valid && !flush;
    if (mem_stall && m.valid) m_stalls++;
    if (t) m_redirects++;
    if (flush || (!held && !ex_valid)) m_bubbles++;
    if (flush) begin
      m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.mtr = 0; m.br = 0; m.jmp = 0;
      m_redirected = 1'b0;
    end else if (held) begin
      if (t) m_redirected = 1'b1;
    end else begin
      m.valid = ex_valid;
      m.alu = ALUResult; m.sd = Reg_Data2; m.rd = RegDestSelected; m.sz = MemSize;
      m.btgt = PC_Plus_Branch; m.pc4 = PCPlusFour; m.jq = j_sll_two; m.zero = Zero;
      m.rw  = ex_valid && RegWrite && (RegDestSelected != 5'd0);
      m.mr  = ex_valid && MemRead;
      m.mw  = ex_valid && MemWrite;
      m.mtr = ex_valid && MemToReg;
      m.br  = ex_valid && Branch;
      m.jmp = ex_valid && Jump;
      m_redirected = 1'b0;
    end
  endtask

  task automatic check_all();
    logic [31:0] tgt;
    tgt = m.jmp ? {m.pc4[31:28], m.jq} : m.btgt;
    chk("mem_valid", 32'(mem_valid), 32'(m.valid));
    chk("ex_stall", 32'(ex_stall), 32'(mem_stall && m.valid));
    chk("mem_ALUResult", mem_ALUResult, m.alu);
    chk("mem_StoreData", mem_StoreData, m.sd);
    chk("mem_RegDest", 32'(mem_RegDest), 32'(m.rd));
    chk("mem_MemSize", 32'(mem_MemSize), 32'(m.sz));
    chk("mem_RegWrite", 32'(mem_RegWrite), 32'(m.rw));
    chk("mem_MemRead", 32'(mem_MemRead), 32'(m.mr));
    chk("mem_MemWrite", 32'(mem_MemWrite), 32'(m.mw));
    chk("mem_MemToReg", 32'(mem_MemToReg), 32'(m.mtr));
    chk("PCSrc", 32'(PCSrc), 32'(m_take()));
    chk("squash_ex", 32'(squash_ex), 32'(m_take()));
    chk("PCTarget", PCTarget, tgt);
    chk("fwd_en", 32'(fwd_en), 32'(m.valid && m.rw && !m.mr));
    chk("fwd_rd", 32'(fwd_rd), 32'(m.rd));
    chk("fwd_data", fwd_data, m.alu);
`ifdef EX_MEM_PERF_CNT_EN
    chk("perf_stall", perf_stall_cnt, m_stalls);
    chk("perf_bubble", perf_bubble_cnt, m_bubbles);
    chk("perf_redirect", perf_redirect_cnt, m_redirects);
`else
    chk("perf_stall", perf_stall_cnt, 32'd0);
    chk("perf_bubble", perf_bubble_cnt, 32'd0);
    chk("perf_redirect", perf_redirect_cnt, 32'd0);
`endif
  endtask

  task automatic step();
    @(posedge Clk);
    if (Rst) model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    ex_valid = 0; Zero = 0; ALUResult = 0; PC_Plus_Branch = 0; PCPlusFour = 0;
    Reg_Data2 = 0; j_sll_two = 0; RegDestSelected = 0; RegWrite = 0; MemRead = 0;
    MemWrite = 0; MemToReg = 0; Branch = 0; Jump = 0; MemSize = 2'b00;
    mem_stall = 0; flush = 0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    idle_inputs();
    Rst = 1'b0;
    model_reset();
    #3;
    check_all();
    chk("reset_mem_valid", 32'(mem_valid), 32'd0);
    Rst = 1'b1;

    // add $16,$8,$12
    ex_valid = 1; ALUResult = 32'h14; RegDestSelected = 5'd16; RegWrite = 1;
    step();
    chk("add_valid", 32'(mem_valid), 32'd1);
    chk("add_rd", 32'(mem_RegDest), 32'd16);
    chk("add_fwd_en", 32'(fwd_en), 32'd1);
    chk("add_fwd_data", fwd_data, 32'h14);

    // beq taken, then held three cycles
    idle_inputs();
    ex_valid = 1; Branch = 1; Zero = 1; PC_Plus_Branch = 32'h40;
    step();
    chk("beq_pcsrc", 32'(PCSrc), 32'd1);
    chk("beq_target", PCTarget, 32'h40);
    idle_inputs();
    mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("beq_held_no_pulse", 32'(PCSrc), 32'd0);
      chk("beq_held_ex_stall", 32'(ex_stall), 32'd1);
    end
    mem_stall = 0;
    step();

    // j
    ex_valid = 1; Jump = 1; PCPlusFour = 32'h1000_0008; j_sll_two = 28'h000_0100;
    step();
    chk("j_pcsrc", 32'(PCSrc), 32'd1);
    chk("j_target", PCTarget, 32'h1000_0100);
    idle_inputs();
    step();
    chk("j_single_pulse", 32'(PCSrc), 32'd0);

    // write to $0, then a load
    ex_valid = 1; RegDestSelected = 5'd0; RegWrite = 1; ALUResult = 32'h55;
    step();
    chk("r0_regwrite", 32'(mem_RegWrite), 32'd0);
    chk("r0_fwd_en", 32'(fwd_en), 32'd0);
    RegDestSelected = 5'd5; MemRead = 1; MemToReg = 1; MemSize = 2'b10;
    step();
    chk("lw_regwrite", 32'(mem_RegWrite), 32'd1);
    chk("lw_fwd_en", 32'(fwd_en), 32'd0);

    // flush beats stall while FULL
    idle_inputs();
    ex_valid = 1; RegDestSelected = 5'd9; RegWrite = 1; MemWrite = 1;
    step();
    flush = 1; mem_stall = 1;
    step();
    chk("flush_valid", 32'(mem_valid), 32'd0);
    chk("flush_regwrite", 32'(mem_RegWrite), 32'd0);
    chk("flush_memwrite", 32'(mem_MemWrite), 32'd0);
    flush = 0; ex_valid = 0;
    #1;
    chk("empty_ex_stall", 32'(ex_stall), 32'd0);

    // asynchronous reset while HELD
    idle_inputs();
    ex_valid = 1; RegDestSelected = 5'd7; RegWrite = 1; ALUResult = 32'hABCD;
    step();
    mem_stall = 1; ex_valid = 0;
    step();
    step();
    #2;
    Rst = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("async_rst_valid", 32'(mem_valid), 32'd0);
    chk("async_rst_alu", mem_ALUResult, 32'd0);
    #3;
    idle_inputs();
    Rst = 1'b1;
    step();
    chk("post_rst_stall_cnt", perf_stall_cnt, 32'd0);
    chk("post_rst_redirect_cnt", perf_redirect_cnt, 32'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      ex_valid        = ($urandom_range(0, 3) != 0);
      Zero            = 1'($urandom_range(0, 1));
      ALUResult       = $urandom;
      Reg_Data2       = $urandom;
      PC_Plus_Branch  = $urandom;
      PCPlusFour      = $urandom;
      j_sll_two       = 28'($urandom);
      RegDestSelected = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      RegWrite        = 1'($urandom_range(0, 1));
      MemRead         = ($urandom_range(0, 3) == 0);
      MemWrite        = ($urandom_range(0, 3) == 0);
      MemToReg        = 1'($urandom_range(0, 1));
      Branch          = ($urandom_range(0, 3) == 0);
      Jump            = ($urandom_range(0, 6) == 0);
      MemSize         = 2'($urandom_range(0, 2));
      mem_stall       = ($urandom_range(0, 9) < 3);
      flush           = ($urandom_range(0, 11) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
